// File: rtl/grf_read_hazard_pkg.sv
// Shared encodings for GRF read-hazard resolution: forward selects and Tnew/Tuse constants.
// Used by the hazard unit and by the decoder that produces Tuse/Tnew.
package grf_read_hazard_pkg;

    typedef enum logic [1:0] {
        FWD_GRF = 2'd0,
        FWD_E   = 2'd1,
        FWD_M   = 2'd2,
        FWD_W   = 2'd3
    } fwd_sel_e;

    typedef enum logic [1:0] {
        EFWD_REG = 2'd0,
        EFWD_M   = 2'd1,
        EFWD_W   = 2'd2
    } efwd_sel_e;

    localparam logic [1:0] TUSE_NONE = 2'd3;
    localparam logic [1:0] TNEW_NONE = 2'd0;
    localparam logic [1:0] TNEW_ALU  = 2'd1;
    localparam logic [1:0] TNEW_LOAD = 2'd2;
    localparam int unsigned GRF_ZERO = 0;

    typedef struct packed {
        logic     stall;
        fwd_sel_e sel;
    } d_res_t;

endpackage

// File: rtl/grf_read_hazard_stage_reg.sv
// One {dst, tnew} shadow pipeline stage with optional saturating Tnew decrement and bubble insert.
module hazard_stage_reg #(
    parameter int AW  = 5,
    parameter int TW  = 2,
    parameter bit DEC = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          bubble,
    input  logic [AW-1:0] in_dst,
    input  logic [TW-1:0] in_tnew,
    output logic [AW-1:0] dst,
    output logic [TW-1:0] tnew
);

    function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] x);
        return (x == '0) ? '0 : x - TW'(1);
    endfunction

    // NOTE: sequential state uses non-blocking assignment so every stage samples the pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dst  <= '0;
            tnew <= '0;
        end else if (bubble) begin
            dst  <= '0;
            tnew <= '0;
        end else begin
            dst  <= in_dst;
            tnew <= DEC ? sat_dec(in_tnew) : in_tnew;
        end
    end

endmodule

// File: rtl/grf_read_hazard.sv
// GRF read-hazard unit: stall request and D/E forward selects from an E/M/W shadow pipeline.
// Optional stall-cycle counter enabled by defining HAZARD_PERF_EN.
module grf_read_hazard
    import grf_read_hazard_pkg::*;
#(
    parameter int AW = 5,
    parameter int TW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] d_rs,
    input  logic [AW-1:0] d_rt,
    input  logic [TW-1:0] d_tuse_rs,
    input  logic [TW-1:0] d_tuse_rt,
    input  logic [AW-1:0] d_dst,
    input  logic [TW-1:0] d_tnew,
    input  logic          flush,
    output logic          stall,
    output logic [1:0]    d_fwd_rs,
    output logic [1:0]    d_fwd_rt,
    output logic [1:0]    e_fwd_rs,
    output logic [1:0]    e_fwd_rt,
    output logic [31:0]   stall_cnt
);

    typedef struct packed {
        logic [AW-1:0] dst;
        logic [TW-1:0] tnew;
    } stage_t;

    stage_t        e_st, m_st, w_st;
    logic [AW-1:0] e_rs, e_rt;
    logic          e_bubble;
    d_res_t        rs_res, rt_res;

    assign e_bubble = stall | flush;

    hazard_stage_reg #(.AW(AW), .TW(TW), .DEC(1'b0)) u_stage_e (
        .clk(clk), .reset(reset), .bubble(e_bubble),
        .in_dst(d_dst), .in_tnew(d_tnew), .dst(e_st.dst), .tnew(e_st.tnew)
    );

    hazard_stage_reg #(.AW(AW), .TW(TW), .DEC(1'b1)) u_stage_m (
        .clk(clk), .reset(reset), .bubble(1'b0),
        .in_dst(e_st.dst), .in_tnew(e_st.tnew), .dst(m_st.dst), .tnew(m_st.tnew)
    );

    hazard_stage_reg #(.AW(AW), .TW(TW), .DEC(1'b1)) u_stage_w (
        .clk(clk), .reset(reset), .bubble(1'b0),
        .in_dst(m_st.dst), .in_tnew(m_st.tnew), .dst(w_st.dst), .tnew(w_st.tnew)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_rs <= '0;
            e_rt <= '0;
        end else if (e_bubble) begin
            e_rs <= '0;
            e_rt <= '0;
        end else begin
            e_rs <= d_rs;
            e_rt <= d_rt;
        end
    end

    // Youngest matching stage decides both the stall and the forward source.
    function automatic d_res_t d_resolve(input logic [AW-1:0] a, input logic [TW-1:0] tuse,
                                         input stage_t e, input stage_t m, input stage_t w);
        d_res_t r;
        stage_t hit;
        logic   found;
        // NOTE: every result field gets a default first so no path leaves it unassigned.
        r     = '{stall: 1'b0, sel: FWD_GRF};
        hit   = '0;
        found = 1'b0;
        if (a != AW'(GRF_ZERO)) begin
            if (a == e.dst) begin
                hit = e; found = 1'b1; r.sel = (e.tnew == '0) ? FWD_E : FWD_GRF;
            end else if (a == m.dst) begin
                hit = m; found = 1'b1; r.sel = (m.tnew == '0) ? FWD_M : FWD_GRF;
            end else if (a == w.dst) begin
                hit = w; found = 1'b1; r.sel = (w.tnew == '0) ? FWD_W : FWD_GRF;
            end
        end
        r.stall = found && (tuse != TW'(TUSE_NONE)) && (hit.tnew > tuse);
        return r;
    endfunction

    function automatic efwd_sel_e e_resolve(input logic [AW-1:0] a, input stage_t m, input stage_t w);
        efwd_sel_e s;
        s = EFWD_REG;
        if (a != AW'(GRF_ZERO)) begin
            if (a == m.dst)
                s = (m.tnew == '0) ? EFWD_M : EFWD_REG;
            else if (a == w.dst && w.tnew == '0)
                s = EFWD_W;
        end
        return s;
    endfunction

    assign rs_res   = d_resolve(d_rs, d_tuse_rs, e_st, m_st, w_st);
    assign rt_res   = d_resolve(d_rt, d_tuse_rt, e_st, m_st, w_st);
    assign stall    = rs_res.stall | rt_res.stall;
    assign d_fwd_rs = rs_res.sel;
    assign d_fwd_rt = rt_res.sel;
    assign e_fwd_rs = e_resolve(e_rs, m_st, w_st);
    assign e_fwd_rt = e_resolve(e_rt, m_st, w_st);

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            stall_cnt_q <= '0;
        else if (stall)
            stall_cnt_q <= stall_cnt_q + 32'd1;
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

    // A still-pending M result reaching an E read means the D stall let something slip.
    a_e_rs_ready: assert property (@(posedge clk) disable iff (!reset)
        !(e_rs != AW'(GRF_ZERO) && e_rs == m_st.dst && m_st.tnew != '0));
    a_e_rt_ready: assert property (@(posedge clk) disable iff (!reset)
        !(e_rt != AW'(GRF_ZERO) && e_rt == m_st.dst && m_st.tnew != '0));

endmodule
